// File: rtl/foc_pkg.sv
// -----------------------------------------------------------------------------
// foc_pkg
// Shared constants, types and helpers for the Clarke-transform front end.
//   DW      : sample width (a, b, alpha, beta)
//   K_*     : Q.6 coefficients (value / 2^SHIFT)
//   PW      : full-precision product width
//   SW      : full-precision beta-sum width (one bit above PW)
//   sample_t: signed DW-bit sample
//   sat_dw(): clamp an SW-bit signed value into the sample_t range
// -----------------------------------------------------------------------------
package foc_pkg;

    localparam int DW      = 16;
    localparam int K_ALPHA = 78;   // 1.21875
    localparam int K_BA    = 45;   // 0.703125
    localparam int K_BB    = 90;   // 1.40625
    localparam int SHIFT   = 6;

    localparam int PW = DW + 8;    // |K| < 2^7, plus a sign bit
    localparam int SW = DW + 9;    // room for the beta sum carry

    typedef logic signed [DW-1:0] sample_t;

    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (DW - 1)));

    function automatic sample_t sat_dw(input logic signed [SW-1:0] x);
        sample_t y;
        if (x > SAT_MAX)      y = {1'b0, {(DW-1){1'b1}}};
        else if (x < SAT_MIN) y = {1'b1, {(DW-1){1'b0}}};
        else                  y = sample_t'(x[DW-1:0]);
        return y;
    endfunction

endpackage

// File: rtl/foc_div_sat.sv
// -----------------------------------------------------------------------------
// foc_div_sat
// Combinational divide-by-2^SHIFT with truncation toward zero, followed by
// saturation to the signed DW range.
//   x_i : full-precision signed value (SW bits)
//   y_o : x_i / 2^SHIFT rounded toward zero, clamped to sample_t
// -----------------------------------------------------------------------------
module foc_div_sat
    import foc_pkg::*;
(
    input  logic signed [SW-1:0] x_i,
    output sample_t              y_o
);

    localparam logic signed [SW-1:0] BIAS = SW'((1 << SHIFT) - 1);

    logic signed [SW-1:0] biased;
    logic signed [SW-1:0] shifted;

    // An arithmetic shift alone rounds toward -inf; biasing negative values by
    // 2^SHIFT-1 first turns that into rounding toward zero. Cannot overflow:
    // SW has headroom far above the largest magnitude the products reach.
    assign biased  = x_i[SW-1] ? (x_i + BIAS) : x_i;
    assign shifted = biased >>> SHIFT;
    assign y_o     = sat_dw(shifted);

endmodule

// File: rtl/foc.sv
// -----------------------------------------------------------------------------
// foc
// Clarke-transform front end: (a, b) -> scaled (alpha, beta), three register
// stages, one sample per clock, no backpressure.
//   clk   : system clock, rising edge
//   rstn  : asynchronous active-low reset, clears every pipeline register
//   i_en  : input valid; a/b sampled on each rising edge with i_en=1
//   a, b  : signed phase currents
//   o_en  : output valid, i_en delayed by three cycles
//   alpha : trunc0(K_ALPHA*a / 2^SHIFT), saturated; holds when o_en=0
//   beta  : trunc0((K_BA*a + K_BB*b) / 2^SHIFT), saturated; holds when o_en=0
// -----------------------------------------------------------------------------
module foc
    import foc_pkg::*;
(
    input  logic    clk,
    input  logic    rstn,
    input  logic    i_en,
    input  sample_t a,
    input  sample_t b,
    output logic    o_en,
    output sample_t alpha,
    output sample_t beta
);

    localparam logic signed [PW-1:0] KA_W  = PW'(K_ALPHA);
    localparam logic signed [PW-1:0] KBA_W = PW'(K_BA);
    localparam logic signed [PW-1:0] KBB_W = PW'(K_BB);

    // Stage 1: raw products.
    logic signed [PW-1:0] pa_q, pba_q, pbb_q;
    logic signed [PW-1:0] pa_d, pba_d, pbb_d;
    logic                 v1_q;

    // Stage 2: alpha product and beta sum at common width.
    logic signed [SW-1:0] sa_q, sb_q;
    logic signed [SW-1:0] sa_d, sb_d;
    logic                 v2_q;

    // Stage 3: output registers.
    sample_t alpha_q, beta_q;
    sample_t alpha_d, beta_d;
    logic    o_en_q;

    // Operands are sign-extended to PW before multiplying so the product
    // is computed at full precision.
    assign pa_d  = KA_W  * PW'(a);
    assign pba_d = KBA_W * PW'(a);
    assign pbb_d = KBB_W * PW'(b);

    assign sa_d = SW'(pa_q);
    assign sb_d = SW'(pba_q) + SW'(pbb_q);

    foc_div_sat u_div_sat_alpha (.x_i(sa_q), .y_o(alpha_d));
    foc_div_sat u_div_sat_beta  (.x_i(sb_q), .y_o(beta_d));

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's pre-edge value, regardless of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pa_q    <= '0;
            pba_q   <= '0;
            pbb_q   <= '0;
            v1_q    <= 1'b0;
            sa_q    <= '0;
            sb_q    <= '0;
            v2_q    <= 1'b0;
            alpha_q <= '0;
            beta_q  <= '0;
            o_en_q  <= 1'b0;
        end else begin
            // Valid bits advance every cycle; data advances only with them.
            v1_q   <= i_en;
            v2_q   <= v1_q;
            o_en_q <= v2_q;
            if (i_en) begin
                pa_q  <= pa_d;
                pba_q <= pba_d;
                pbb_q <= pbb_d;
            end
            if (v1_q) begin
                sa_q <= sa_d;
                sb_q <= sb_d;
            end
            if (v2_q) begin
                alpha_q <= alpha_d;
                beta_q  <= beta_d;
            end
        end
    end

    assign o_en  = o_en_q;
    assign alpha = alpha_q;
    assign beta  = beta_q;

endmodule

// File: tb/tb_foc.sv
// -----------------------------------------------------------------------------
// tb_foc
// Directed self-checking bench for foc. Inputs change on the falling edge,
// outputs are compared on the falling edge (half a cycle after the active edge).
// -----------------------------------------------------------------------------
module tb_foc;

    logic               clk = 1'b0;
    logic               rstn;
    logic               i_en;
    logic signed [15:0] a, b;
    logic               o_en;
    logic signed [15:0] alpha, beta;

    int errors = 0;
    int checks = 0;

    foc dut (
        .clk   (clk),
        .rstn  (rstn),
        .i_en  (i_en),
        .a     (a),
        .b     (b),
        .o_en  (o_en),
        .alpha (alpha),
        .beta  (beta)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic en,
                             input int ea, input int eb);
        check({tag, ".o_en"},  32'(o_en), 32'(en));
        check({tag, ".alpha"}, 32'(alpha), ea);
        check({tag, ".beta"},  32'(beta), eb);
    endtask

    // One sample, then idle; checks o_en stays low for two cycles and the
    // result appears after the third edge.
    task automatic single(input string tag, input int sa, input int sb,
                          input int ea, input int eb);
        @(negedge clk);
        i_en = 1'b1; a = 16'(sa); b = 16'(sb);
        @(negedge clk);
        i_en = 1'b0;
        check({tag, ".lat1"}, 32'(o_en), 0);
        @(negedge clk);
        check({tag, ".lat2"}, 32'(o_en), 0);
        @(negedge clk);
        check_out(tag, 1'b1, ea, eb);
    endtask

    initial begin
        rstn = 1'b0; i_en = 1'b0; a = '0; b = '0;

        // Reset held with i_en toggling: everything stays cleared.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_en = ~i_en; a = 16'(1000 + i); b = 16'(i);
            check_out("rst_hold", 1'b0, 0, 0);
        end
        @(negedge clk);
        i_en = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        check_out("rst_rel", 1'b0, 0, 0);

        // Directed values.
        single("v1000_0",    1000,   0,      1218,   703);
        single("v500_300",   500,    300,    609,    773);
        single("v800_m200",  800,    -200,   975,    281);
        single("vm500_300",  -500,   300,    -609,   70);
        single("vm700_m600", -700,   -600,   -853,   -1335);
        single("vm16k_m12k", -16000, -12000, -19500, -28125);
        single("v16384_1e4", 16384,  10000,  19968,  25582);
        single("vmax",       32767,  32767,  32767,  32767);
        single("vmin",       -32768, -32768, -32768, -32768);

        // Held outputs after idle cycles.
        @(negedge clk);
        check_out("hold_idle", 1'b0, -32768, -32768);

        // Back-to-back samples.
        @(negedge clk); i_en = 1'b1; a = 16'(1000);  b = 16'(0);
        @(negedge clk); i_en = 1'b1; a = 16'(-500);  b = 16'(300);
        @(negedge clk); i_en = 1'b1; a = 16'(16384); b = 16'(10000);
        @(negedge clk); i_en = 1'b0; a = 16'(7);     b = 16'(7);
        check_out("b2b0", 1'b1, 1218, 703);
        @(negedge clk);
        check_out("b2b1", 1'b1, -609, 70);
        @(negedge clk);
        check_out("b2b2", 1'b1, 19968, 25582);
        @(negedge clk);
        check_out("b2b_hold", 1'b0, 19968, 25582);

        // Reset one cycle after accepting a sample.
        @(negedge clk); i_en = 1'b1; a = 16'(500); b = 16'(300);
        @(negedge clk); i_en = 1'b0;
        rstn = 1'b0;
        #1;
        check_out("mid_rst", 1'b0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_out("mid_rst_post", 1'b0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/foc.md
Name: foc

Overview:
- Clarke-transform front end of the field-oriented-control (FOC) datapath.
- Converts two signed phase-current samples (a, b) into scaled stationary-frame components (alpha, beta).
- Fully pipelined: three register stages, one sample accepted per clock.
- Sits between the current-sense ADC interface and the downstream Park/PI stages.

Parameters:
- DW, 16, width of the a, b, alpha and beta signed two's-complement words.
- K_ALPHA, 78, alpha coefficient on a (78/64 = 1.21875).
- K_BA, 45, beta coefficient on a (45/64 = 0.703125).
- K_BB, 90, beta coefficient on b (90/64 = 1.40625).
- SHIFT, 6, fractional bits of all coefficients (divide by 64).

Ports:
- clk  input  1  system clock, rising-edge active.
- rstn  input  1  asynchronous active-low reset.
- i_en  input  1  input-valid strobe; a and b are sampled on every rising edge where i_en=1.
- a  input  DW  phase-A current, signed.
- b  input  DW  phase-B current, signed.
- o_en  output  1  output-valid strobe; one cycle high per accepted sample.
- alpha  output  DW  signed, trunc0(K_ALPHA*a / 2^SHIFT), saturated.
- beta  output  DW  signed, trunc0((K_BA*a + K_BB*b) / 2^SHIFT), saturated.

Behaviour:
- Reset (rstn=0, asynchronous): all pipeline registers, alpha, beta and o_en go to 0. Any in-flight samples are discarded and no o_en is produced for them.
- Arithmetic is exact integer math, with no intermediate truncation.
  - Products are full width: DW + 8 bits minimum.
  - The beta sum is at least DW + 9 bits.
- Division by 2^SHIFT truncates toward zero, not toward -infinity.
  - Negative value: add 2^SHIFT-1 before the arithmetic right shift.
  - Non-negative value: plain arithmetic right shift.
- After division, saturate each result to the signed DW range [-32768, 32767].
- Pipeline, for a sample accepted at edge N:
  - Stage 1 (edge N): register K_ALPHA*a, K_BA*a and K_BB*b, together with a valid bit.
  - Stage 2 (edge N+1): register the alpha product and the beta sum, with the valid bit.
  - Stage 3 (edge N+2): round-toward-zero shift and saturate into the alpha/beta output registers; o_en=1.
- Latency: 3 rising edges from the edge sampling i_en=1 to the edge after which o_en=1 and the matching alpha/beta are valid.
- Throughput: one sample per cycle.
  - Back-to-back i_en produces back-to-back o_en pulses, in order.
  - There is no backpressure.
- o_en is i_en delayed by exactly 3 cycles (through reset-cleared flops).
- alpha and beta update only on stages carrying valid data. Otherwise they hold their last value.
- Inputs are ignored while i_en=0. Repeated i_en with unchanged inputs recomputes the same result.
- All outputs are registered; there is no combinational path from input to output.

Decomposition:
- Shared package foc_pkg holds:
  - DW, the coefficient and SHIFT constants;
  - a signed sample typedef (logic signed [DW-1:0]);
  - a saturate-to-DW helper function.
- One natural sub-module, foc_div_sat, implements the round-toward-zero shift plus saturation as a combinational block. Stage 3 instantiates it twice (alpha, beta).

Test Plan:
- Reset: hold rstn=0 with i_en toggling -> alpha=0, beta=0, o_en=0 throughout. Release -> first o_en exactly 3 cycles after the first sampled i_en=1.
- Directed values, one i_en per sample, check when o_en=1:
  - (1000,0) -> alpha=1218, beta=703
  - (500,300) -> 609, 773
  - (800,-200) -> 975, 281
- Negative truncation toward zero:
  - (-500,300) -> alpha=-609, beta=70
  - (-700,-600) -> -853, -1335
  - (-16000,-12000) -> -19500, -28125
- Large in-range and saturation:
  - (16384,10000) -> 19968, 25582
  - (32767,32767) -> 32767, 32767
  - (-32768,-32768) -> -32768, -32768
- Throughput: 3 consecutive i_en=1 cycles with different samples -> 3 consecutive o_en pulses, correct values in order. Then i_en=0 -> o_en=0 and outputs hold.
- Reset mid-pipeline: assert rstn=0 one cycle after i_en -> outputs clear immediately, no o_en after release.
